lockstep_fifo: RTL and testbench

- Parametrised redundant synchronous FIFO: NLANES independent copies of storage and pointers, all written and read by one shared handshake.
- Lane outputs and fill levels are cross-compared every cycle. Any divergence raises a sticky error with a per-lane mask.
- Used as a self-checking buffer in datapaths and as a formal lockstep target; generalises the two-copy XOR-compare FIFO pair.

---
 rtl/lockstep_fifo.sv | 164 ++++++++++++++++
 tb/tb_lockstep_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lockstep_fifo.sv
// lockstep_fifo: NLANES redundant synchronous FIFOs driven by one shared
// write/read handshake. Lane outputs and fill levels are cross-checked every
// cycle against lane 0; any divergence pulses o_mismatch and sets the sticky
// o_err / o_err_lanes flags until the next reset.
//
// Handshake: a write is taken on a rising edge when i_wr=1 and the lane is not
// full; a read is taken when i_rd=1 and the lane is not empty. Refused
// requests are dropped, not held. Read data appears one cycle after an
// accepted read, qualified by o_valid.
//
// Optional macro LOCKSTEP_FIFO_VOTE_EN (NLANES must be odd): o_data/o_valid
// become the bitwise majority of all lanes instead of lane 0 alone.
module lockstep_fifo #(
  parameter int WIDTH   = 8,
  parameter int LGDEPTH = 4,
  parameter int NLANES  = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [NLANES-1:0]  i_flip,
  output logic               o_full,
  input  logic               i_rd,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_valid,
  output logic               o_empty,
  output logic [LGDEPTH:0]   o_fill,
  output logic               o_mismatch,
  output logic               o_err,
  output logic [NLANES-1:0]  o_err_lanes
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam int PW    = LGDEPTH + 1;

  logic [NLANES-1:0][WIDTH-1:0] lane_data;
  logic [NLANES-1:0]            lane_valid;
  logic [NLANES-1:0][PW-1:0]    lane_fill;
  logic                         lane0_full;
  logic                         lane0_empty;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] wdata;
    logic             full, empty, wr_acc, rd_acc;

    // Flags come from this lane's own registered pointers only.
    assign full   = (wr_ptr_q[LGDEPTH] != rd_ptr_q[LGDEPTH]) &&
                    (wr_ptr_q[LGDEPTH-1:0] == rd_ptr_q[LGDEPTH-1:0]);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign wr_acc = i_wr && !full;
    assign rd_acc = i_rd && !empty;

    // Fault-injection hook: optionally invert bit 0 of the stored word.
    always_comb begin
      wdata    = i_data;
      wdata[0] = i_data[0] ^ i_flip[k];
    end

    // Next pointers and read port; data holds when no read is taken.
    always_comb begin
      wr_ptr_d = wr_ptr_q + (wr_acc ? PW'(1) : PW'(0));
      rd_ptr_d = rd_ptr_q + (rd_acc ? PW'(1) : PW'(0));
      rvalid_d = rd_acc;
      rdata_d  = rd_acc ? mem_q[rd_ptr_q[LGDEPTH-1:0]] : rdata_q;
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge i_clk) begin
      if (!i_reset && wr_acc) mem_q[wr_ptr_q[LGDEPTH-1:0]] <= wdata;
    end

    // Pointer and read-output registers.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign lane_data[k]  = rdata_q;
    assign lane_valid[k] = rvalid_q;
    // Modular difference is exact at full because pointers carry an extra bit.
    assign lane_fill[k]  = wr_ptr_q - rd_ptr_q;

    if (k == 0) begin : g_ref
      assign lane0_full  = full;
      assign lane0_empty = empty;
    end
  end

  // Per-lane divergence against lane 0; bit 0 summarises the others.
  logic [NLANES-1:0] diff_d;
  always_comb begin
    diff_d = '0;
    for (int k = 1; k < NLANES; k++) begin
      diff_d[k] = (lane_valid[k] != lane_valid[0]) ||
                  (lane_fill[k] != lane_fill[0]) ||
                  (lane_valid[0] && (lane_data[k] != lane_data[0]));
    end
    diff_d[0] = |diff_d[NLANES-1:1];
  end

  logic              mismatch_q;
  logic              err_q;
  logic [NLANES-1:0] err_lanes_q;

  // Registered compare stage and sticky error accumulation.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mismatch_q  <= 1'b0;
      err_q       <= 1'b0;
      err_lanes_q <= '0;
    end else begin
      mismatch_q  <= |diff_d;
      err_q       <= err_q | mismatch_q;
      err_lanes_q <= err_lanes_q | diff_d;
    end
  end

`ifdef LOCKSTEP_FIFO_VOTE_EN
  logic [WIDTH-1:0] vote_data;
  logic             vote_valid;
  // Bitwise majority so a single faulty lane is outvoted.
  always_comb begin
    int cnt;
    vote_data  = '0;
    vote_valid = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      cnt = 0;
      for (int k = 0; k < NLANES; k++) cnt += int'(lane_data[k][b]);
      vote_data[b] = (cnt > NLANES / 2);
    end
    cnt = 0;
    for (int k = 0; k < NLANES; k++) cnt += int'(lane_valid[k]);
    vote_valid = (cnt > NLANES / 2);
  end
  assign o_data  = vote_data;
  assign o_valid = vote_valid;
`else
  assign o_data  = lane_data[0];
  assign o_valid = lane_valid[0];
`endif

  assign o_full      = lane0_full;
  assign o_empty     = lane0_empty;
  assign o_fill      = lane_fill[0];
  assign o_mismatch  = mismatch_q;
  assign o_err       = err_q;
  assign o_err_lanes = err_lanes_q;

endmodule

// File: tb/tb_lockstep_fifo.sv
// Testbench for lockstep_fifo: directed steps from the test plan followed by
// randomized traffic, checked each cycle against a queue-based reference model.
module tb_lockstep_fifo;

  localparam int WIDTH   = 8;
  localparam int LGDEPTH = 4;
  localparam int NLANES  = 3;
  localparam int DEPTH   = 1 << LGDEPTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_reset = 1'b1;
  logic              i_wr = 1'b0;
  logic              i_rd = 1'b0;
  logic [WIDTH-1:0]  i_data = '0;
  logic [NLANES-1:0] i_flip = '0;
  logic              o_full, o_valid, o_empty, o_mismatch, o_err;
  logic [WIDTH-1:0]  o_data;
  logic [LGDEPTH:0]  o_fill;
  logic [NLANES-1:0] o_err_lanes;

  lockstep_fifo #(.WIDTH(WIDTH), .LGDEPTH(LGDEPTH), .NLANES(NLANES)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wr(i_wr), .i_data(i_data),
    .i_flip(i_flip), .o_full(o_full), .i_rd(i_rd), .o_data(o_data),
    .o_valid(o_valid), .o_empty(o_empty), .o_fill(o_fill),
    .o_mismatch(o_mismatch), .o_err(o_err), .o_err_lanes(o_err_lanes)
  );

  // ---------------- scoreboard / reference model ----------------
  // Each queued entry: {flip mask applied at write, written data}.
  logic [NLANES+WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]  m_data;
  logic              m_valid;
  logic              m_mis;
  logic              m_err;
  logic [NLANES-1:0] m_lanes;
  logic [NLANES-1:0] m_diff;   // divergence visible on lane outputs now
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of the output copy of bit 0's flip given the per-lane flip mask.
  function automatic logic out_flip(input logic [NLANES-1:0] f);
`ifdef LOCKSTEP_FIFO_VOTE_EN
    return ($countones(f) > NLANES / 2);
`else
    return f[0];
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_data = '0; m_valid = 1'b0; m_mis = 1'b0; m_err = 1'b0;
    m_lanes = '0; m_diff = '0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input logic [WIDTH-1:0] d,
                            input logic [NLANES-1:0] f);
    bit acc_w, acc_r;
    logic [NLANES+WIDTH-1:0] e;
    logic [NLANES-1:0] ef;
    acc_w = wr && (exp_q.size() < DEPTH);
    acc_r = rd && (exp_q.size() > 0);
    m_err   = m_err | m_mis;
    m_mis   = (m_diff != '0);
    m_lanes = m_lanes | m_diff;
    m_diff  = '0;
    m_valid = 1'b0;
    if (acc_r) begin
      e  = exp_q.pop_front();
      ef = e[NLANES+WIDTH-1:WIDTH];
      m_valid = 1'b1;
      m_data  = e[WIDTH-1:0];
      m_data[0] = m_data[0] ^ out_flip(ef);
      for (int k = 1; k < NLANES; k++) m_diff[k] = (ef[k] != ef[0]);
      m_diff[0] = |m_diff[NLANES-1:1];
    end
    if (acc_w) exp_q.push_back({f, d});
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit wr, input bit rd,
                      input logic [WIDTH-1:0] d, input logic [NLANES-1:0] f);
    @(negedge clk);
    i_reset = rst; i_wr = wr; i_rd = rd; i_data = d; i_flip = f;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step(wr, rd, d, f);
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("data", 32'(o_data), 32'(m_data));
    chk("fill", 32'(o_fill), 32'(exp_q.size()));
    chk("full", 32'(o_full), 32'(exp_q.size() == DEPTH));
    chk("empty", 32'(o_empty), 32'(exp_q.size() == 0));
    chk("mismatch", 32'(o_mismatch), 32'(m_mis));
    chk("err", 32'(o_err), 32'(m_err));
    chk("err_lanes", 32'(o_err_lanes), 32'(m_lanes));
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] plan1 [3];
    plan1[0] = 8'h11; plan1[1] = 8'h22; plan1[2] = 8'h33;

    model_reset();
    step(1, 0, 0, '0, '0);
    step(1, 1, 1, 8'hFF, '0);   // request ignored during reset
    // Direct reset-value checks independent of the model.
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_fill", 32'(o_fill), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);

    // 1: three writes then three reads.
    for (int i = 0; i < 3; i++) step(0, 1, 0, plan1[i], '0);
    chk("t1_fill3", 32'(o_fill), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, '0, '0);
      chk("t1_rdata", 32'(o_data), 32'(plan1[i]));
    end
    idle();

    // 2: fill to full, overflow write, simultaneous rd+wr while full, drain.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(8'h40 + i), '0);
    chk("t2_full", 32'(o_full), 32'd1);
    chk("t2_fill16", 32'(o_fill), 32'd16);
    step(0, 1, 0, 8'hEE, '0);
    step(0, 1, 1, 8'hDD, '0);
    chk("t2_fill15", 32'(o_fill), 32'd15);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0, '0);

    // 3: read while empty, then rd+wr while empty.
    step(0, 0, 1, '0, '0);
    chk("t3_novalid", 32'(o_valid), 32'd0);
    step(0, 1, 1, 8'h5C, '0);
    chk("t3_fill1", 32'(o_fill), 32'd1);
    step(0, 0, 1, '0, '0);
    idle();

    // 4: single-lane fault on lane 1.
    step(0, 1, 0, 8'hA4, 3'b010);
    step(0, 0, 1, '0, '0);
`ifdef LOCKSTEP_FIFO_VOTE_EN
    chk("t4_vote", 32'(o_data), 32'hA4);
`endif
    idle();
    chk("t4_mis_pulse", 32'(o_mismatch), 32'd1);
    idle();
    idle();
    chk("t4_err", 32'(o_err), 32'd1);
    chk("t4_lanes", 32'(o_err_lanes), 32'b011);

    // 5: mixed traffic long enough to wrap pointers several times.
    for (int i = 0; i < 160; i++)
      step(0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
           WIDTH'($urandom), '0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, '0, '0);

    // 6: reset mid-burst with the sticky error set.
    for (int i = 0; i < 5; i++) step(0, 1, i[0], WIDTH'($urandom), '0);
    step(1, 1, 1, 8'h77, '0);
    chk("t6_err_clr", 32'(o_err), 32'd0);
    chk("t6_lanes_clr", 32'(o_err_lanes), 32'd0);
    step(0, 0, 1, '0, '0);

    // Randomized traffic with occasional lane faults.
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
           WIDTH'($urandom),
           ($urandom_range(0, 7) == 0) ? NLANES'($urandom_range(0, 7)) : '0);
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 1, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
